// File: rtl/tilelink.sv
// Shared TileLink-UL definitions: A/D channel beat layouts and the opcodes used by
// the RAM responder.
package TL;

  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
  } tilelink_a;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [7:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_valid;
  } tilelink_d;

  function automatic logic is_put(input logic [2:0] opcode);
    return (opcode == PUT_FULL_DATA) || (opcode == PUT_PARTIAL_DATA);
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Two-entry D-channel response queue; entry 0 is always the head, and a push and
// pop in the same cycle are accepted even when full.
module tl_resp_fifo
  import TL::*;
(
  input  logic       clock,
  input  logic       srst,
  input  logic       push,
  input  logic       pop,
  input  tilelink_d  push_data,
  output tilelink_d  head,
  output logic [1:0] count
);

  tilelink_d  entry_reg [2];
  logic [1:0] count_reg;

  always_ff @(posedge clock) begin
    if (srst) begin
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          entry_reg[count_reg[0]] <= push_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new beat lands behind whatever survives the pop.
          if (count_reg == 2'd1) begin
            entry_reg[0] <= push_data;
          end else if (count_reg == 2'd2) begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/tilelink_ram_responder.sv
// TileLink-UL slave backed by an inferred word RAM: one request accepted per cycle,
// responses one cycle later, in order, through an inflight stage plus a 2-entry queue.
module tilelink_ram_responder
  import TL::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter logic [3:0]  TAG   = 4'h8
) (
  input  logic      clock,
  input  logic      tick_reset_in,
  input  tilelink_a tla,
  output logic      tla_ready,
  output tilelink_d tld,
  input  logic      tld_ready
);

  localparam int AW = $clog2(WORDS);

  logic [31:0] mem [WORDS];
  logic [31:0] rd_data_reg;

  logic        inflight_reg;
  tilelink_d   inflight_meta_reg;
  logic        inflight_use_ram_reg;

  logic [1:0]  fifo_count;
  tilelink_d   fifo_head;
  logic        fifo_push;
  logic        fifo_pop;

  logic        claim;
  logic        accept;
  logic        pop;
  logic        d_valid;
  logic [1:0]  occupancy;
  logic [25:0] word_index;
  logic [AW-1:0] ram_addr;
  logic        out_of_range;
  logic        is_get;
  logic        is_put_op;
  logic        ram_write;
  tilelink_d   accept_meta;
  tilelink_d   inflight_entry;
  tilelink_d   head;
  logic        unused_bits;

  always_comb begin
    claim        = tla.a_valid && (tla.a_address[31:28] == TAG);
    word_index   = tla.a_address[27:2];
    ram_addr     = word_index[AW-1:0];
    out_of_range = {6'd0, word_index} >= WORDS;
    is_get       = (tla.a_opcode == GET);
    is_put_op    = is_put(tla.a_opcode);

    occupancy = fifo_count + {1'b0, inflight_reg};
    d_valid   = !tick_reset_in && ((fifo_count != 2'd0) || inflight_reg);
    pop       = d_valid && tld_ready;
    // Ready looks through a pop in progress so a full pipe still streams at one beat per cycle.
    tla_ready = !tick_reset_in && ((occupancy < 2'd2) || pop);
    accept    = claim && tla_ready;
    ram_write = accept && is_put_op && !out_of_range;

    fifo_pop  = pop && (fifo_count != 2'd0);
    // The inflight beat bypasses the queue only when it is the head and is taken now.
    fifo_push = inflight_reg && !(pop && (fifo_count == 2'd0));

    accept_meta          = '0;
    accept_meta.d_opcode = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    accept_meta.d_size   = tla.a_size;
    accept_meta.d_source = tla.a_source;
    accept_meta.d_denied = out_of_range || !(is_get || is_put_op);
    accept_meta.d_valid  = 1'b1;

    inflight_entry        = inflight_meta_reg;
    inflight_entry.d_data = inflight_use_ram_reg ? rd_data_reg : 32'd0;

    head        = (fifo_count != 2'd0) ? fifo_head : inflight_entry;
    tld         = head;
    tld.d_valid = d_valid;
  end

  assign unused_bits = ^{tla.a_param, tla.a_address[1:0]};

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= accept;
    end
    if (accept) begin
      inflight_meta_reg    <= accept_meta;
      inflight_use_ram_reg <= is_get && !out_of_range;
    end
  end

  // RAM contents survive reset; writes only ever happen on an accepted in-range Put.
  always_ff @(posedge clock) begin
    if (accept) begin
      rd_data_reg <= mem[ram_addr];
    end
    if (ram_write) begin
      for (int b = 0; b < 4; b++) begin
        if (tla.a_mask[b]) begin
          mem[ram_addr][b*8 +: 8] <= tla.a_data[b*8 +: 8];
        end
      end
    end
  end

  tl_resp_fifo u_resp_fifo (
    .clock     (clock),
    .srst      (tick_reset_in),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (inflight_entry),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_tilelink_ram_responder.sv
// Bench for tilelink_ram_responder: directed and random A-channel traffic checked
// every cycle against a queue-of-responses reference model with its own memory image.
module tb_tilelink_ram_responder;
  import TL::*;

  logic      clock = 1'b0;
  logic      tick_reset_in;
  tilelink_a tla;
  logic      tla_ready;
  tilelink_d tld;
  logic      tld_ready;

  int vectors     = 0;
  int miscompares = 0;

  tilelink_d   exp_q [$];
  logic [31:0] model_mem [4096];

  tilelink_ram_responder dut (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .tla           (tla),
    .tla_ready     (tla_ready),
    .tld           (tld),
    .tld_ready     (tld_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] fields(input tilelink_d d);
    return {14'd0, d.d_opcode, d.d_param, d.d_size, d.d_source, d.d_denied, d.d_data};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one accepted request: response contents plus memory effect.
  function automatic tilelink_d model_access(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [3:0] mask, input logic [31:0] data,
                                             input logic [3:0] size, input logic [7:0] src);
    tilelink_d r;
    int  idx = int'(addr[27:2]);
    bit  oor = (idx >= 4096);
    r = '0;
    r.d_size   = size;
    r.d_source = src;
    r.d_valid  = 1'b1;
    if (op == 3'd4) begin
      r.d_opcode = 3'd1;
      if (oor) r.d_denied = 1'b1;
      else     r.d_data   = model_mem[idx];
    end else if (op == 3'd0 || op == 3'd1) begin
      r.d_opcode = 3'd0;
      if (oor) begin
        r.d_denied = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end else begin
      r.d_opcode = 3'd0;
      r.d_denied = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [2:0] op,
                      input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic dr);
    logic      exp_ready, exp_valid, claim;
    tilelink_d resp;
    tick_reset_in = rst;
    tla           = '0;
    tla.a_valid   = v;
    tla.a_opcode  = op;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    tla.a_size    = 4'd2;
    tla.a_source  = 8'($urandom_range(0, 255));
    tld_ready     = dr;
    @(negedge clock);
    exp_valid = !rst && (exp_q.size() > 0);
    exp_ready = !rst && ((exp_q.size() < 2) || (exp_valid && dr));
    check("tla_ready", {63'd0, tla_ready}, {63'd0, exp_ready});
    check("d_valid", {63'd0, tld.d_valid}, {63'd0, exp_valid});
    if (exp_valid) check("d_resp", fields(tld), fields(exp_q[0]));
    claim = v && (addr[31:28] == 4'h8);
    @(posedge clock);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_valid && dr) void'(exp_q.pop_front());
      if (claim && exp_ready) begin
        resp = model_access(op, addr, mask, data, tla.a_size, tla.a_source);
        exp_q.push_back(resp);
      end
    end
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, 3'd4, 32'h0, 4'h0, 32'h0, dr);
  endtask

  initial begin
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [25:0] idx;
    int          r;

    step(1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 3'd4, 32'h8000_0000, 4'h0, 32'h0, 1'b1);

    // Seed the low 16 words so every later read has a known value.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 3'd0, 32'h8000_0000 + 32'(4 * i), 4'hF, $urandom, 1'b1);
    idle(1'b1);

    // Full put then read-after-write, then a byte-masked overwrite.
    step(1'b0, 1'b1, 3'd0, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b1, 3'd1, 32'h8000_0010, 4'b0001, 32'h0000_00AA, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    check("raw_model_word", {32'd0, model_mem[4]}, 64'hDEAD_BEAA);

    // Backpressure: two gets stall the third, releasing D lets it in the same cycle.
    step(1'b0, 1'b1, 3'd4, 32'h8000_0010, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0004, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0008, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0008, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Out-of-range get/put (aliases word 0 if the range check were missing).
    step(1'b0, 1'b1, 3'd4, 32'h8001_0000, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'd0, 32'h8001_0000, 4'hF, 32'h1234_5678, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0000, 4'h0, 32'h0, 1'b1);
    // Unclaimed tag, zero-mask put, unsupported opcode.
    step(1'b0, 1'b1, 3'd4, 32'h4000_0000, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'd1, 32'h8000_0014, 4'h0, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0014, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'd2, 32'h8000_0018, 4'hF, 32'h5555_5555, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0018, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      op = 3'd4;
      else if (r < 70) op = 3'd0;
      else if (r < 92) op = 3'd1;
      else             op = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd5;
      tag = ($urandom_range(0, 9) != 0) ? 4'h8 : 4'($urandom_range(0, 15));
      idx = ($urandom_range(0, 9) != 0) ? 26'($urandom_range(0, 15))
                                        : 26'(4096 + $urandom_range(0, 5000));
      step(1'b0, $urandom_range(0, 9) < 7, op, {tag, idx, 2'b00}, 4'($urandom),
           $urandom, $urandom_range(0, 3) != 0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset with two responses pending: they vanish, memory survives.
    step(1'b0, 1'b1, 3'd4, 32'h8000_000C, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0014, 4'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 3'd0, 32'h8000_000C, 4'hF, 32'hBAD0_BAD0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 32'h8000_000C, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 3'd4, 32'h8000_0010, 4'h0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
